// File: rtl/cache_ctrl.sv
// cache_ctrl: two-way set-associative, write-back, write-allocate cache
// controller. The tag and data RAMs are external with one-cycle
// registered-address read latency. Main memory is accessed one 128-bit
// line at a time over a req/ack handshake.
module cache_ctrl #(
   parameter int INDEX_BIT          = 10,
   parameter int BLOCK_SIZE_WORDS   = 4,
   parameter int NUMBER_OF_SETS     = 1000,
   parameter int TOTAL_TAG_SIZE_BIT = 23
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          cpu_req,
   input  logic                          cpu_we,
   input  logic [31:0]                   cpu_addr,
   input  logic [31:0]                   cpu_wdata,
   output logic                          cpu_ready,
   output logic [31:0]                   cpu_rdata,
   output logic                          cpu_err,
   output logic                          busy,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [31:0]                   mem_addr,
   output logic [32*BLOCK_SIZE_WORDS-1:0] mem_wdata,
   input  logic                          mem_ack,
   input  logic [32*BLOCK_SIZE_WORDS-1:0] mem_rdata,
   output logic [INDEX_BIT-1:0]          ram_index,
   output logic                          tag0_we,
   output logic                          tag1_we,
   output logic [TOTAL_TAG_SIZE_BIT-1:0] tag0_wdata,
   output logic [TOTAL_TAG_SIZE_BIT-1:0] tag1_wdata,
   input  logic [TOTAL_TAG_SIZE_BIT-1:0] tag0_rdata,
   input  logic [TOTAL_TAG_SIZE_BIT-1:0] tag1_rdata,
   output logic                          db0_we,
   output logic                          db1_we,
   output logic [32*BLOCK_SIZE_WORDS-1:0] db0_wdata,
   output logic [32*BLOCK_SIZE_WORDS-1:0] db1_wdata,
   input  logic [32*BLOCK_SIZE_WORDS-1:0] db0_rdata,
   input  logic [32*BLOCK_SIZE_WORDS-1:0] db1_rdata
);

   localparam int LINE_BITS = 32 * BLOCK_SIZE_WORDS;
   localparam int TW        = TOTAL_TAG_SIZE_BIT;
   localparam int TAG_W     = 28 - INDEX_BIT;          // address tag bits
   localparam int PAD_W     = TW - 3 - TAG_W;          // zero pad in entry
   localparam int V_BIT     = TW - 1;
   localparam int U_BIT     = TW - 2;
   localparam int D_BIT     = TW - 3;

   typedef enum logic [2:0] {
      IDLE, TAG_RD, COMPARE, WRITEBACK, REFILL, INSTALL, DONE
   } state_t;

   state_t                state;
   logic                  req_we;
   logic [31:2]           req_addr;
   logic [31:0]           req_wdata;
   logic                  victim_way;
   logic [TW-1:0]         other_tag;
   logic [LINE_BITS-1:0]  fill_line;

   logic [TAG_W-1:0]      req_tag;
   logic [INDEX_BIT-1:0]  req_idx;
   logic [1:0]            req_off;
   logic                  hit0, hit1, hit, hit_way;
   logic                  miss_way;
   logic [TW-1:0]         vic_entry;
   logic [LINE_BITS-1:0]  vic_line;
   logic [TW-1:0]         new_tag;
   logic [TW-1:0]         other_clr;
   logic [LINE_BITS-1:0]  install_line;
   logic                  cmp_wr, ins_wr;
   logic                  acc_err;

   // Word 0 sits in the most significant 32 bits of the line.
   function automatic logic [31:0] get_word(input logic [LINE_BITS-1:0] line,
                                            input logic [1:0] off);
      logic [6:0] lsb;
      lsb = {~off, 5'b0};
      return line[lsb +: 32];
   endfunction

   function automatic logic [LINE_BITS-1:0] merge_word(input logic [LINE_BITS-1:0] line,
                                                       input logic [1:0] off,
                                                       input logic [31:0] word);
      logic [LINE_BITS-1:0] res;
      logic [6:0]           lsb;
      res = line;
      lsb = {~off, 5'b0};
      res[lsb +: 32] = word;
      return res;
   endfunction

   assign req_tag = req_addr[31:4+INDEX_BIT];
   assign req_idx = req_addr[INDEX_BIT+3:4];
   assign req_off = req_addr[3:2];

   assign acc_err = (cpu_addr[1:0] != 2'b00) ||
                    ({{(32-INDEX_BIT){1'b0}}, cpu_addr[INDEX_BIT+3:4]} >= 32'(NUMBER_OF_SETS));

   assign hit0    = tag0_rdata[V_BIT] && (tag0_rdata[TAG_W-1:0] == req_tag);
   assign hit1    = tag1_rdata[V_BIT] && (tag1_rdata[TAG_W-1:0] == req_tag);
   assign hit     = hit0 || hit1;
   assign hit_way = !hit0;                  // way0 wins a double match

   // Victim: first invalid way, then the not-recently-used way, else way0.
   assign miss_way  = !tag0_rdata[V_BIT] ? 1'b0 :
                      !tag1_rdata[V_BIT] ? 1'b1 :
                      !tag0_rdata[U_BIT] ? 1'b0 :
                      !tag1_rdata[U_BIT] ? 1'b1 : 1'b0;
   assign vic_entry = miss_way ? tag1_rdata : tag0_rdata;
   assign vic_line  = miss_way ? db1_rdata  : db0_rdata;

   assign new_tag      = {1'b1, 1'b1, req_we, {PAD_W{1'b0}}, req_tag};
   assign other_clr    = {other_tag[V_BIT], 1'b0, other_tag[D_BIT:0]};
   assign install_line = req_we ? merge_word(fill_line, req_off, req_wdata) : fill_line;

   // Write strobes are qualified with reset_n so a reset edge never lands
   // a partial tag or data update in the RAMs.
   assign cmp_wr = (state == COMPARE) && hit && reset_n;
   assign ins_wr = (state == INSTALL) && reset_n;

   assign busy = (state != IDLE);

   // RAM write strobes and write data; active only in COMPARE (hit) and INSTALL.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      tag0_we    = 1'b0;
      tag1_we    = 1'b0;
      db0_we     = 1'b0;
      db1_we     = 1'b0;
      tag0_wdata = '0;
      tag1_wdata = '0;
      db0_wdata  = '0;
      db1_wdata  = '0;
      if (cmp_wr) begin
         tag0_we           = 1'b1;
         tag1_we           = 1'b1;
         tag0_wdata        = tag0_rdata;
         tag0_wdata[U_BIT] = !hit_way;
         tag0_wdata[D_BIT] = tag0_rdata[D_BIT] | (req_we & !hit_way);
         tag1_wdata        = tag1_rdata;
         tag1_wdata[U_BIT] = hit_way;
         tag1_wdata[D_BIT] = tag1_rdata[D_BIT] | (req_we & hit_way);
         if (req_we) begin
            if (!hit_way) begin
               db0_we    = 1'b1;
               db0_wdata = merge_word(db0_rdata, req_off, req_wdata);
            end else begin
               db1_we    = 1'b1;
               db1_wdata = merge_word(db1_rdata, req_off, req_wdata);
            end
         end
      end else if (ins_wr) begin
         tag0_we = 1'b1;
         tag1_we = 1'b1;
         if (!victim_way) begin
            tag0_wdata = new_tag;
            tag1_wdata = other_clr;
            db0_we     = 1'b1;
            db0_wdata  = install_line;
         end else begin
            tag1_wdata = new_tag;
            tag0_wdata = other_clr;
            db1_we     = 1'b1;
            db1_wdata  = install_line;
         end
      end
   end

   // Control FSM with registered CPU and memory-side outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!reset_n) begin
         state      <= IDLE;
         req_we     <= 1'b0;
         req_addr   <= '0;
         req_wdata  <= '0;
         victim_way <= 1'b0;
         other_tag  <= '0;
         fill_line  <= '0;
         cpu_ready  <= 1'b0;
         cpu_rdata  <= '0;
         cpu_err    <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         ram_index  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cpu_req) begin
                  req_we    <= cpu_we;
                  req_addr  <= cpu_addr[31:2];
                  req_wdata <= cpu_wdata;
                  if (acc_err) begin
                     cpu_err   <= 1'b1;
                     cpu_ready <= 1'b1;
                     state     <= DONE;
                  end else begin
                     ram_index <= cpu_addr[INDEX_BIT+3:4];
                     state     <= TAG_RD;
                  end
               end
            end
            TAG_RD: state <= COMPARE;
            COMPARE: begin
               if (hit) begin
                  if (!req_we)
                     cpu_rdata <= get_word(hit_way ? db1_rdata : db0_rdata, req_off);
                  cpu_ready <= 1'b1;
                  state     <= DONE;
               end else begin
                  // mem_addr/mem_wdata hold the victim tag and line for writeback.
                  victim_way <= miss_way;
                  other_tag  <= miss_way ? tag0_rdata : tag1_rdata;
                  mem_req    <= 1'b1;
                  if (vic_entry[V_BIT] && vic_entry[D_BIT]) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= {vic_entry[TAG_W-1:0], req_idx, 4'b0};
                     mem_wdata <= vic_line;
                     state     <= WRITEBACK;
                  end else begin
                     mem_we    <= 1'b0;
                     mem_addr  <= {req_tag, req_idx, 4'b0};
                     mem_wdata <= '0;
                     state     <= REFILL;
                  end
               end
            end
            WRITEBACK: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= REFILL;
               end
            end
            REFILL: begin
               // After a writeback the fetch is launched one cycle after the ack.
               if (!mem_req) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= {req_tag, req_idx, 4'b0};
                  mem_wdata <= '0;
               end else if (mem_ack) begin
                  fill_line <= mem_rdata;
                  mem_req   <= 1'b0;
                  state     <= INSTALL;
               end
            end
            INSTALL: begin
               if (!req_we)
                  cpu_rdata <= get_word(fill_line, req_off);
               cpu_ready <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               cpu_ready <= 1'b0;
               cpu_err   <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench for cache_ctrl with behavioural tag/data
// RAMs, a handshake memory responder and an expected-response queue.
module tb_cache_ctrl;

   logic          clk;
   logic          reset_n;
   logic          cpu_req, cpu_we;
   logic [31:0]   cpu_addr, cpu_wdata;
   logic          cpu_ready, cpu_err, busy;
   logic [31:0]   cpu_rdata;
   logic          mem_req, mem_we, mem_ack;
   logic [31:0]   mem_addr;
   logic [127:0]  mem_wdata, mem_rdata;
   logic [9:0]    ram_index;
   logic          tag0_we, tag1_we, db0_we, db1_we;
   logic [22:0]   tag0_wdata, tag1_wdata, tag0_rdata, tag1_rdata;
   logic [127:0]  db0_wdata, db1_wdata, db0_rdata, db1_rdata;

   logic [22:0]   tag0_mem [0:1023];
   logic [22:0]   tag1_mem [0:1023];
   logic [127:0]  db0_mem  [0:1023];
   logic [127:0]  db1_mem  [0:1023];

   typedef struct {
      logic        chk_rdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;
   exp_t sb_q[$];

   int checks = 0;
   int errors = 0;
   int cycle_cnt = 0;
   int start_cycle = 0;
   int tag_we_cnt = 0, db_we_cnt = 0, mem_req_cyc = 0, we_bad = 0;

   localparam logic [127:0] L0  = 128'h0000_0014_0000_0015_0000_0016_0000_0017;
   localparam logic [127:0] L0W = 128'h0000_0014_0000_0015_DEAD_BEEF_0000_0017;
   localparam logic [127:0] LF  = 128'hA1A1_0001_B2B2_0002_C3C3_0003_D4D4_0004;
   localparam logic [127:0] LG  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [127:0] LH  = 128'hCAFE_0006_0000_0000_0000_0000_0000_0001;

   cache_ctrl #(
      .INDEX_BIT(10), .BLOCK_SIZE_WORDS(4), .NUMBER_OF_SETS(1000), .TOTAL_TAG_SIZE_BIT(23)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .busy(busy),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ram_index(ram_index),
      .tag0_we(tag0_we), .tag1_we(tag1_we),
      .tag0_wdata(tag0_wdata), .tag1_wdata(tag1_wdata),
      .tag0_rdata(tag0_rdata), .tag1_rdata(tag1_rdata),
      .db0_we(db0_we), .db1_we(db1_we),
      .db0_wdata(db0_wdata), .db1_wdata(db1_wdata),
      .db0_rdata(db0_rdata), .db1_rdata(db1_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAMs with registered address: read data one cycle later.
   always @(posedge clk) begin
      if (tag0_we) tag0_mem[ram_index] <= tag0_wdata;
      if (tag1_we) tag1_mem[ram_index] <= tag1_wdata;
      if (db0_we)  db0_mem[ram_index]  <= db0_wdata;
      if (db1_we)  db1_mem[ram_index]  <= db1_wdata;
      tag0_rdata <= tag0_mem[ram_index];
      tag1_rdata <= tag1_mem[ram_index];
      db0_rdata  <= db0_mem[ram_index];
      db1_rdata  <= db1_mem[ram_index];
   end

   // Activity counters sampled at each clock edge.
   always @(posedge clk) begin
      cycle_cnt   = cycle_cnt + 1;
      tag_we_cnt  = tag_we_cnt + int'(tag0_we) + int'(tag1_we);
      db_we_cnt   = db_we_cnt + int'(db0_we) + int'(db1_we);
      mem_req_cyc = mem_req_cyc + int'(mem_req);
      if ((tag0_we || tag1_we || db0_we || db1_we) && (!busy || cpu_ready))
         we_bad = we_bad + 1;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [22:0] mk_tag(input logic v, input logic u, input logic d,
                                          input logic [17:0] t);
      return {v, u, d, 2'b00, t};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic chk, input logic [31:0] rd, input logic err,
                            input int lat);
      exp_t e;
      e.chk_rdata = chk;
      e.rdata     = rd;
      e.err       = err;
      e.lat       = lat;
      sb_q.push_back(e);
      @(negedge clk);
      cpu_req     = 1'b1;
      cpu_we      = we;
      cpu_addr    = addr;
      cpu_wdata   = wdata;
      start_cycle = cycle_cnt;
   endtask

   task automatic wait_done(input string name);
      exp_t e;
      logic got;
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (cpu_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      check({name, "_ready_seen"}, got, 1'b1);
      e = sb_q.pop_front();
      if (got) begin
         check({name, "_err"}, cpu_err, e.err);
         if (e.chk_rdata) check({name, "_rdata"}, cpu_rdata, e.rdata);
         if (e.lat > 0)   check({name, "_latency"}, cycle_cnt - start_cycle, e.lat);
      end
      cpu_req = 1'b0;
      @(posedge clk);
      #1;
      check({name, "_ready_pulse"}, cpu_ready, 1'b0);
   endtask

   task automatic wait_mem_req(input string name);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (mem_req === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      check({name, "_mem_req_seen"}, got, 1'b1);
   endtask

   task automatic mem_serve(input string name, input logic exp_we, input logic [31:0] exp_addr,
                            input logic [127:0] exp_wdata, input int delay,
                            input logic [127:0] rdata);
      wait_mem_req(name);
      check({name, "_mem_we"}, mem_we, exp_we);
      check({name, "_mem_addr"}, mem_addr, exp_addr);
      if (exp_we) check({name, "_mem_wdata"}, mem_wdata, exp_wdata);
      repeat (delay) @(posedge clk);
      #1;
      check({name, "_mem_hold"}, {mem_req, mem_we, mem_addr}, {1'b1, exp_we, exp_addr});
      @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      check({name, "_mem_req_drop"}, mem_req, 1'b0);
   endtask

   initial begin
      int t_snap, d_snap, m_snap;
      reset_n   = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      for (int i = 0; i < 1024; i++) begin
         tag0_mem[i] = '0;
         tag1_mem[i] = '0;
         db0_mem[i]  = '0;
         db1_mem[i]  = '0;
      end
      tag0_mem[5] = mk_tag(1'b1, 1'b0, 1'b0, 18'd3);
      db0_mem[5]  = L0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_cpu", {cpu_ready, cpu_err, busy, cpu_rdata}, '0);
      check("rst_mem", {mem_req, mem_we, mem_addr}, '0);
      check("rst_we", {tag0_we, tag1_we, db0_we, db1_we}, '0);
      check("rst_index", ram_index, '0);
      @(negedge clk);
      reset_n = 1'b1;

      // Read hit, way0, set 5
      m_snap = mem_req_cyc;
      start_req(1'b0, 32'h0000_C058, '0, 1'b1, 32'h0000_0016, 1'b0, 3);
      wait_done("rd_hit");
      check("rd_hit_tag0", tag0_mem[5], mk_tag(1'b1, 1'b1, 1'b0, 18'd3));
      check("rd_hit_tag1", tag1_mem[5], '0);
      check("rd_hit_no_mem", mem_req_cyc - m_snap, 0);

      // Write hit, way0
      m_snap = mem_req_cyc;
      start_req(1'b1, 32'h0000_C058, 32'hDEAD_BEEF, 1'b0, '0, 1'b0, 3);
      wait_done("wr_hit");
      check("wr_hit_line", db0_mem[5], L0W);
      check("wr_hit_tag0", tag0_mem[5], mk_tag(1'b1, 1'b1, 1'b1, 18'd3));
      check("wr_hit_no_mem", mem_req_cyc - m_snap, 0);

      // Clean miss into invalid way1
      start_req(1'b0, 32'h0001_C050, '0, 1'b1, 32'hA1A1_0001, 1'b0, 0);
      mem_serve("cl_miss", 1'b0, 32'h0001_C050, '0, 5, LF);
      wait_done("cl_miss");
      check("cl_miss_tag1", tag1_mem[5], mk_tag(1'b1, 1'b1, 1'b0, 18'd7));
      check("cl_miss_tag0", tag0_mem[5], mk_tag(1'b1, 1'b0, 1'b1, 18'd3));
      check("cl_miss_line", db1_mem[5], LF);

      // Dirty eviction of way0 (V1,U0,D1,tag3) while way1 is MRU tag7
      start_req(1'b0, 32'h0002_4050, '0, 1'b1, 32'h1111_2222, 1'b0, 0);
      mem_serve("evict_wb", 1'b1, 32'h0000_C050, L0W, 3, '0);
      mem_serve("evict_fill", 1'b0, 32'h0002_4050, '0, 2, LG);
      wait_done("evict");
      check("evict_tag0", tag0_mem[5], mk_tag(1'b1, 1'b1, 1'b0, 18'd9));
      check("evict_tag1", tag1_mem[5], mk_tag(1'b1, 1'b0, 1'b0, 18'd7));
      check("evict_line", db0_mem[5], LG);

      // Error requests: index 1000 and misaligned byte address
      t_snap = tag_we_cnt;
      d_snap = db_we_cnt;
      m_snap = mem_req_cyc;
      start_req(1'b0, 32'h0000_3E80, '0, 1'b0, '0, 1'b1, 1);
      wait_done("err_index");
      start_req(1'b1, 32'h0000_C059, 32'h1234_5678, 1'b0, '0, 1'b1, 1);
      wait_done("err_align");
      check("err_no_we", {tag_we_cnt - t_snap, db_we_cnt - d_snap}, '0);
      check("err_no_mem", mem_req_cyc - m_snap, 0);
      check("err_line_kept", db0_mem[5], LG);

      // Reset while REFILL has mem_req high
      start_req(1'b0, 32'h0000_8060, '0, 1'b1, 32'hCAFE_0006, 1'b0, 0);
      wait_mem_req("rst_refill");
      t_snap = tag_we_cnt;
      d_snap = db_we_cnt;
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_outputs", {mem_req, busy, cpu_ready}, '0);
      @(negedge clk);
      reset_n = 1'b1;
      cpu_req = 1'b0;
      void'(sb_q.pop_front());
      check("rst_mid_no_we", {tag_we_cnt - t_snap, db_we_cnt - d_snap}, '0);
      check("rst_mid_tags", {tag0_mem[6], tag1_mem[6]}, '0);
      check("rst_mid_line", db0_mem[6], '0);

      // Same request after reset is serviced normally
      start_req(1'b0, 32'h0000_8060, '0, 1'b1, 32'hCAFE_0006, 1'b0, 0);
      mem_serve("post_rst", 1'b0, 32'h0000_8060, '0, 3, LH);
      wait_done("post_rst");
      check("post_rst_tag0", tag0_mem[6], mk_tag(1'b1, 1'b1, 1'b0, 18'd2));
      check("post_rst_line", db0_mem[6], LH);

      // Follow-up read hit on the line installed by the dirty eviction
      start_req(1'b0, 32'h0002_405C, '0, 1'b1, 32'h7777_8888, 1'b0, 3);
      wait_done("rd_hit2");

      check("we_outside_active", we_bad, 0);
      check("sb_empty", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameters: INDEX_BIT, default 10, set index width; BLOCK_SIZE_WORDS, default 4, words per line; NUMBER_OF_SETS, default 1000, implemented sets; TOTAL_TAG_SIZE_BIT, default 23, tag entry width.
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- cpu_req  in  1  request; held high until cpu_ready.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write word.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read word, valid with cpu_ready.
- cpu_err  out  1  error flag, valid with cpu_ready.
- busy  out  1  high whenever the controller is not IDLE.
- mem_req  out  1  main-memory request.
- mem_we  out  1  1=line writeback, 0=line fetch.
- mem_addr  out  32  line-aligned address.
- mem_wdata  out  128  writeback line.
- mem_ack  in  1  one-cycle memory completion pulse.
- mem_rdata  in  128  fetched line, valid with mem_ack.
- ram_index  out  INDEX_BIT  index to all four RAMs.
- tag0_we, tag1_we  out  1  tag RAM write enables.
- tag0_wdata, tag1_wdata  out  23  tag write data.
- tag0_rdata, tag1_rdata  in  23  tag read data; 1-cycle registered-address latency.
- db0_we, db1_we  out  1  data RAM write enables.
- db0_wdata, db1_wdata  out  128  data write lines.
- db0_rdata, db1_rdata  in  128  data read lines; 1-cycle latency.

Function
REQ-003 SHALL decode cpu_addr as: tag [31:14] (18 bits); index [13:4]; word offset [3:2]; byte [1:0].
REQ-004 SHALL map word offset 0/1/2/3 to line bits [127:96]/[95:64]/[63:32]/[31:0] respectively.
REQ-005 SHALL use tag entry format [22] valid, [21] used (MRU), [20] dirty, [19:0] = {2'b00, tag}.
REQ-006 SHALL implement states IDLE, TAG_RD, COMPARE, WRITEBACK, REFILL, INSTALL and DONE.
REQ-007 SHALL sample cpu_req in IDLE only and register address, data and cpu_we at acceptance.
- Request with cpu_addr[1:0]!=0, or index >= NUMBER_OF_SETS: go to DONE with cpu_err=1; no RAM or memory writes.
- Otherwise: go to TAG_RD.
REQ-008 TAG_RD SHALL drive ram_index from the registered index and hold it stable until DONE.
- No writes in TAG_RD.
- Next state is COMPARE.
REQ-009 COMPARE SHALL declare a hit in way w when tagw valid=1 and tagw[17:0] equals the request tag.
- If both ways match, way0 wins.
REQ-010 On a read hit, SHALL register the selected word into cpu_rdata and go to DONE.
REQ-011 On a write hit, SHALL write the line with only the addressed word replaced and set dirty=1 in way w.
REQ-012 On any hit, SHALL write both tags in the same cycle: way w used=1, other way used=0, all other fields unchanged.
REQ-013 On a miss, SHALL select the victim as the first invalid way (way0 first); else the way with used=0; else way0.
- SHALL register the victim's tag and line, and the other way's tag entry.
REQ-014 Victim valid and dirty: SHALL go to WRITEBACK with mem_we=1, mem_addr={victim tag[17:0], index, 4'b0} and mem_wdata = victim line.
- Otherwise: SHALL go to REFILL.
REQ-015 REFILL SHALL assert mem_req=1, mem_we=0, mem_addr={req tag, index, 4'b0}.
REQ-016 mem_req and the memory outputs SHALL stay constant until mem_ack.
- mem_ack is ignored while mem_req=0.
- mem_req drops in the cycle after mem_ack.
- WRITEBACK then moves to REFILL; REFILL captures mem_rdata and moves to INSTALL.
REQ-017 INSTALL SHALL write the victim data RAM with the fetched line, with the addressed word merged if cpu_we=1.
- Victim tag becomes {1,1,cpu_we,tag}; the other way's tag is rewritten with used=0.
- On a read, cpu_rdata takes the fetched word.
- Next state is DONE.
REQ-018 DONE SHALL pulse cpu_ready for exactly one cycle, then return to IDLE.
- cpu_err=0 unless set per REQ-007.
- A new request is acceptable in the following IDLE cycle.
REQ-019 Latency from acceptance edge to cpu_ready high: hit = 3 cycles; error = 1 cycle.
REQ-020 All *_we outputs SHALL be single-cycle pulses.
- Never asserted in IDLE, TAG_RD, WRITEBACK, REFILL or DONE.

Reset
REQ-021 While reset_n=0 at a clk edge, state SHALL become IDLE.
- All outputs become 0, including every write enable; no RAM write occurs in that cycle.
REQ-022 Reset mid-transaction SHALL abandon it without any partial tag or data write.
- mem_req drops in the next cycle.

Verification
REQ-023 Bench SHALL cover these scenarios:
- Read hit: set5 way0 {V1,U0,D0,tag3}, line word2 = 0x0000_0016; read 0x0000_C058 -> cpu_rdata 0x16, cpu_ready 3 cycles after accept; tag0 U=1, tag1 U=0; mem_req never high.
- Write hit: write 0x0000_C058 data 0xDEAD_BEEF -> db0[5][63:32] = 0xDEADBEEF, tag0[5] D=1, no memory traffic.
- Clean miss, way1 invalid: read 0x0001_C050 -> fetch at 0x0001_C050; ack after 5 cycles -> tag1[5] = {1,1,0,tag 7}, tag0 U=0, cpu_rdata = mem_rdata[127:96].
- Dirty eviction: way0 {V1,U0,D1,tag3}, way1 {V1,U1,tag7}; read 0x0002_4050 -> writeback at 0x0000_C050 with db0 line, then fetch 0x0002_4050; way0 installed with tag 9.
- Errors: read 0x0000_3E80 (index 1000) or 0x0000_C059 -> cpu_err=1 with cpu_ready 1 cycle after accept; no write enables.
- Reset during REFILL with mem_req high -> next cycle mem_req=0, busy=0, no tag/data writes; next request services normally.
